// File: rtl/led_flash_multi.sv
// led_flash_multi: multi-channel LED flasher driven by a shared prescaled tick.
// Each channel runs OFF / ON / BLINK / BURST, configured through a single-cycle
// write port. Optional PWM brightness is enabled by defining LED_FLASH_PWM_EN.
module led_flash_multi #(
  parameter int CLK_RATE = 100000000,
  parameter int TICK_HZ  = 1000,
  parameter int NUM_CH   = 4,
  parameter int MS_W     = 16,
  parameter int CNT_W    = 8,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [MS_W-1:0]   cfg_on_ms,
  input  logic [MS_W-1:0]   cfg_off_ms,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [7:0]        cfg_bright,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] burst_done
);

  localparam int TICK_CYCLES = CLK_RATE / TICK_HZ;
  localparam int PRE_W       = $clog2(TICK_CYCLES);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } phase_e;

  logic [PRE_W-1:0]  pre_r;
  logic              tick_s;

  mode_e             mode_r   [NUM_CH];
  mode_e             mode_n   [NUM_CH];
  logic [MS_W-1:0]   on_len_r [NUM_CH];
  logic [MS_W-1:0]   on_len_n [NUM_CH];
  logic [MS_W-1:0]   off_len_r[NUM_CH];
  logic [MS_W-1:0]   off_len_n[NUM_CH];
  logic [CNT_W-1:0]  rem_r    [NUM_CH];
  logic [CNT_W-1:0]  rem_n    [NUM_CH];
  phase_e            phase_r  [NUM_CH];
  phase_e            phase_n  [NUM_CH];
  logic [MS_W-1:0]   cnt_r    [NUM_CH];
  logic [MS_W-1:0]   cnt_n    [NUM_CH];
  logic [MS_W-1:0]   len_s    [NUM_CH];
  logic [NUM_CH-1:0] idle_r;
  logic [NUM_CH-1:0] idle_n;
  logic [NUM_CH-1:0] sel_s;
  logic [NUM_CH-1:0] raw_n;
  logic [NUM_CH-1:0] led_n;
  logic [NUM_CH-1:0] done_n;
  logic [NUM_CH-1:0] led_r;
  logic [NUM_CH-1:0] done_r;

  assign tick_s = (pre_r == PRE_W'(TICK_CYCLES - 1));

  // Free-running prescaler; never disturbed by channel writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r <= {PRE_W{1'b0}};
    end else if (tick_s) begin
      pre_r <= {PRE_W{1'b0}};
    end else begin
      pre_r <= pre_r + PRE_W'(1);
    end
  end

  // Per-channel next state: a write wins over a same-cycle tick.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      mode_n[i]    = mode_r[i];
      on_len_n[i]  = on_len_r[i];
      off_len_n[i] = off_len_r[i];
      rem_n[i]     = rem_r[i];
      phase_n[i]   = phase_r[i];
      cnt_n[i]     = cnt_r[i];
      idle_n[i]    = idle_r[i];
      done_n[i]    = 1'b0;
      raw_n[i]     = 1'b0;
      len_s[i]     = (phase_r[i] == PH_ON) ? on_len_r[i] : off_len_r[i];
      sel_s[i]     = cfg_we && (int'(cfg_ch) < NUM_CH) && (int'(cfg_ch) == i);

      if (sel_s[i]) begin
        mode_n[i]    = mode_e'(cfg_mode);
        on_len_n[i]  = (cfg_on_ms == MS_W'(0)) ? MS_W'(1) : cfg_on_ms;
        off_len_n[i] = (cfg_off_ms == MS_W'(0)) ? MS_W'(1) : cfg_off_ms;
        rem_n[i]     = cfg_count;
        phase_n[i]   = PH_ON;
        cnt_n[i]     = MS_W'(0);
        idle_n[i]    = (cfg_mode == 2'd3) && (cfg_count == CNT_W'(0));
        done_n[i]    = (cfg_mode == 2'd3) && (cfg_count == CNT_W'(0));
      end else if (tick_s && !idle_r[i] &&
                   ((mode_r[i] == MODE_BLINK) || (mode_r[i] == MODE_BURST))) begin
        if (cnt_r[i] == (len_s[i] - MS_W'(1))) begin
          cnt_n[i] = MS_W'(0);
          if (phase_r[i] == PH_ON) begin
            phase_n[i] = PH_OFF;
            if (mode_r[i] == MODE_BURST) begin
              rem_n[i] = rem_r[i] - CNT_W'(1);
            end else begin
              rem_n[i] = rem_r[i];
            end
          end else if ((mode_r[i] == MODE_BURST) && (rem_r[i] == CNT_W'(0))) begin
            idle_n[i] = 1'b1;
            done_n[i] = 1'b1;
          end else begin
            phase_n[i] = PH_ON;
          end
        end else begin
          cnt_n[i] = cnt_r[i] + MS_W'(1);
        end
      end else begin
        cnt_n[i] = cnt_r[i];
      end

      case (mode_n[i])
        MODE_OFF:   raw_n[i] = 1'b0;
        MODE_ON:    raw_n[i] = 1'b1;
        MODE_BLINK: raw_n[i] = (phase_n[i] == PH_ON);
        MODE_BURST: raw_n[i] = !idle_n[i] && (phase_n[i] == PH_ON);
        default:    raw_n[i] = 1'b0;
      endcase
    end
  end

`ifdef LED_FLASH_PWM_EN
  logic [7:0] pwm_r;
  logic [7:0] bright_r[NUM_CH];
  logic [7:0] bright_n[NUM_CH];

  // Brightness gating: a lit channel drives pwm_cnt < bright.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      bright_n[i] = sel_s[i] ? cfg_bright : bright_r[i];
      led_n[i]    = raw_n[i] && (pwm_r < bright_n[i]);
    end
  end

  // Global PWM counter and per-channel brightness storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_r <= 8'd0;
      for (int i = 0; i < NUM_CH; i++) begin
        bright_r[i] <= 8'd0;
      end
    end else begin
      pwm_r <= pwm_r + 8'd1;
      for (int i = 0; i < NUM_CH; i++) begin
        bright_r[i] <= bright_n[i];
      end
    end
  end
`else
  logic bright_unused_s;
  assign bright_unused_s = ^cfg_bright;

  // Without PWM the LED is the raw on/off state.
  always_comb begin
    led_n = raw_n;
  end
`endif

  // Channel state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mode_r[i]    <= MODE_OFF;
        on_len_r[i]  <= MS_W'(1);
        off_len_r[i] <= MS_W'(1);
        rem_r[i]     <= CNT_W'(0);
        phase_r[i]   <= PH_ON;
        cnt_r[i]     <= MS_W'(0);
      end
      idle_r <= {NUM_CH{1'b0}};
      led_r  <= {NUM_CH{1'b0}};
      done_r <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        mode_r[i]    <= mode_n[i];
        on_len_r[i]  <= on_len_n[i];
        off_len_r[i] <= off_len_n[i];
        rem_r[i]     <= rem_n[i];
        phase_r[i]   <= phase_n[i];
        cnt_r[i]     <= cnt_n[i];
      end
      idle_r <= idle_n;
      led_r  <= led_n;
      done_r <= done_n;
    end
  end

  assign led        = led_r;
  assign burst_done = done_r;

endmodule
